// File: rtl/booth_mult_rv.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both sides.
// One Booth step per clock, WIDTH+1 steps per product, signed or unsigned per transaction.
module booth_mult_rv #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    output logic                 dest_valid,
    input  logic                 dest_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      count;
    logic [N:0]         a_reg;
    logic [N:0]         u_reg;
    logic [N-1:0]       q_reg;
    logic               qm1_reg;
    logic [N:0]         u_sum;
    logic [2*WIDTH-1:0] product_next;
    logic               last_iter;

    // The accumulator carries one guard bit beyond the extended operand so add/sub can never overflow.
    always_comb begin
        u_sum = u_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   u_sum = u_reg + a_reg;
            2'b10:   u_sum = u_reg - a_reg;
            default: u_sum = u_reg;
        endcase
    end

    assign product_next = {u_sum[WIDTH-1:0], q_reg[WIDTH:1]};
    assign last_iter    = (count == CW'(WIDTH));
    assign src_ready    = (state == IDLE);
    assign dest_valid   = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = src_valid ? CALC : IDLE;
            CALC:    state_next = last_iter ? DONE : CALC;
            DONE:    state_next = dest_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operands captured only on the accept edge; product only written on the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            a_reg   <= '0;
            u_reg   <= '0;
            q_reg   <= '0;
            qm1_reg <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (src_valid) begin
                        a_reg   <= {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
                        q_reg   <= {is_signed & multiplier[WIDTH-1], multiplier};
                        u_reg   <= '0;
                        qm1_reg <= 1'b0;
                        count   <= '0;
                    end
                end
                CALC: begin
                    u_reg   <= {u_sum[N], u_sum[N:1]};
                    q_reg   <= {u_sum[0], q_reg[N-1:1]};
                    qm1_reg <= q_reg[0];
                    count   <= count + 1'b1;
                    if (last_iter) begin
                        product <= product_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_rv.sv
// Self-checking bench for booth_mult_rv: a per-cycle protocol/arithmetic model plus
// hand-computed product literals, with a WIDTH=8 instance for the narrow regression.
module tb_booth_mult_rv;

    logic        clk;
    logic        reset;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        is_signed;
    logic        dest_valid;
    logic        dest_ready;
    logic [31:0] product;

    logic        src_valid8;
    logic        src_ready8;
    logic [7:0]  multiplicand8;
    logic [7:0]  multiplier8;
    logic        is_signed8;
    logic        dest_valid8;
    logic        dest_ready8;
    logic [15:0] product8;

    int errors = 0;
    int checks = 0;

    // Model state: phase 0 = waiting for operands, 1 = computing, 2 = holding a result.
    int          m_phase = 0;
    int          m_left = 0;
    int          m_accepts = 0;
    int          cyc = 0;
    bit          m_live = 0;
    logic [31:0] m_pending = '0;
    logic [31:0] m_product = '0;

    booth_mult_rv #(.WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready),
        .multiplicand(multiplicand), .multiplier(multiplier), .is_signed(is_signed),
        .dest_valid(dest_valid), .dest_ready(dest_ready), .product(product)
    );

    booth_mult_rv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .src_valid(src_valid8), .src_ready(src_ready8),
        .multiplicand(multiplicand8), .multiplier(multiplier8), .is_signed(is_signed8),
        .dest_valid(dest_valid8), .dest_ready(dest_ready8), .product(product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint x;
        longint y;
        longint p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[31:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x;
        longint y;
        longint p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_phase   = 0;
            m_left    = 0;
            m_product = '0;
            m_live    = 1;
        end else if (m_live) begin
            case (m_phase)
                0: if (src_valid) begin
                    m_pending = ref16(multiplicand, multiplier, is_signed);
                    m_left    = 17;
                    m_phase   = 1;
                    m_accepts++;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_product = m_pending;
                        m_phase   = 2;
                    end
                end
                default: if (dest_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("cycle_model", 64'({src_ready, dest_valid, product}),
                        64'({m_phase == 0, m_phase == 2, m_product}));
        end
    end

    // Present operands and keep them until the model records an accept.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s, input logic rdy);
        int prev;
        int n;
        prev = m_accepts;
        @(posedge clk); #1;
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        dest_ready   = rdy;
        src_valid    = 1'b1;
        n = 0;
        while (m_accepts == prev && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        src_valid = 1'b0;
        if (m_accepts == prev) checkOutput("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (dest_valid) break;
        end
        if (!dest_valid) checkOutput("result_timeout", 64'(0), 64'(1));
    endtask

    task automatic runTxn(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [31:0] lit);
        int lat;
        applyStimulus(a, b, s, 1'b1);
        waitResult(lat);
        checkOutput({name, "_latency"}, 64'(lat), 64'(17));
        checkOutput({name, "_product"}, 64'(product), 64'(lit));
        checkOutput({name, "_model"}, 64'(m_product), 64'(lit));
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] lit);
        int n;
        @(posedge clk); #1;
        multiplicand8 = a;
        multiplier8   = b;
        is_signed8    = s;
        dest_ready8   = 1'b1;
        src_valid8    = 1'b1;
        @(posedge clk); #1;
        src_valid8 = 1'b0;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (dest_valid8) break;
            n++;
        end
        if (!dest_valid8) checkOutput({name, "_timeout"}, 64'(0), 64'(1));
        checkOutput({name, "_product"}, 64'(product8), 64'(lit));
        checkOutput({name, "_model"}, 64'(ref8(a, b, s)), 64'(lit));
    endtask

    initial begin
        int lat;
        int prev;
        int last_cyc;
        int n;
        int seen;
        reset = 1'b1;
        src_valid = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        is_signed = 1'b0;
        dest_ready = 1'b0;
        src_valid8 = 1'b0;
        multiplicand8 = '0;
        multiplier8 = '0;
        is_signed8 = 1'b0;
        dest_ready8 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 64'({src_ready, dest_valid, product}), 64'({1'b1, 1'b0, 32'h0}));
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] directed products");
        runTxn("u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        runTxn("s_8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        runTxn("s_m1x3", 16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD);
        runTxn("s_7fff", 16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001);
        runTxn("s_m1m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        runTxn("u_zero", 16'h0000, 16'hBEEF, 1'b0, 32'h00000000);
        runTxn("s_mix", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);

        $display("[TB] backpressure hold");
        applyStimulus(16'h1234, 16'h0010, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("hold_first", 64'(product), 64'(32'h00012340));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            src_valid    = 1'b1;
            multiplicand = 16'h5555;
            multiplier   = 16'h0003;
            dest_ready   = 1'b0;
            @(negedge clk);
            checkOutput("hold_stable", 64'({src_ready, dest_valid, product}),
                        64'({1'b0, 1'b1, 32'h00012340}));
        end
        @(posedge clk); #1;
        src_valid  = 1'b0;
        dest_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("hold_release", 64'({src_ready, dest_valid, product}),
                    64'({1'b1, 1'b0, 32'h00012340}));

        $display("[TB] reset abort in CALC");
        applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_state", 64'({src_ready, dest_valid, product}), 64'({1'b1, 1'b0, 32'h0}));
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (dest_valid) seen++;
        end
        checkOutput("abort_no_valid", 64'(seen), 64'(0));
        runTxn("after_abort", 16'd3, 16'd5, 1'b0, 32'd15);

        $display("[TB] back-to-back random");
        @(posedge clk); #1;
        dest_ready   = 1'b1;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        is_signed    = 1'($urandom_range(0, 1));
        src_valid    = 1'b1;
        prev = m_accepts;
        last_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            n = 0;
            while (m_accepts == prev && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            if (m_accepts == prev) begin
                checkOutput("b2b_timeout", 64'(0), 64'(1));
                break;
            end
            prev = m_accepts;
            if (i > 0) checkOutput("b2b_gap", 64'(cyc - last_cyc), 64'(19));
            last_cyc = cyc;
            multiplicand = 16'($urandom);
            multiplier   = 16'($urandom);
            is_signed    = 1'($urandom_range(0, 1));
        end
        src_valid = 1'b0;
        repeat (25) @(posedge clk);

        $display("[TB] WIDTH=8 regression");
        run8("w8_signed", 8'h80, 8'h7F, 1'b1, 16'hC080);
        run8("w8_unsigned", 8'h80, 8'h7F, 1'b0, 16'h3F80);
        run8("w8_s_m1m1", 8'hFF, 8'hFF, 1'b1, 16'h0001);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
